wb_mem_arbiter: RTL and testbench
=================================

Name: wb_mem_arbiter

Overview:
Two-master to one-slave Wishbone-classic arbiter. It lets the core's instruction-fetch port (M0) and data port (M1) share a single memory bus on boards built without the second memory. It sits between the core and the Controller's core_* bus. It uses round-robin grant, holds the grant until the transfer completes, and has an optional bus-timeout that returns an error to the stalled master.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 255, cycles in a grant without s_ack_i before abort; 0 disables the timeout
TIMEOUT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_cyc_i  in  1  instruction master cycle
m0_stb_i  in  1  instruction master strobe
m0_we_i  in  1  instruction master write enable
m0_addr_i  in  ADDR_WIDTH  instruction master address
m0_data_i  in  DATA_WIDTH  instruction master write data
m0_data_o  out  DATA_WIDTH  read data to M0
m0_ack_o  out  1  ack to M0
m0_err_o  out  1  timeout error to M0
m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o, m1_err_o  same as M0, for the data master
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_addr_o  out  ADDR_WIDTH  slave address
s_data_o  out  DATA_WIDTH  slave write data
s_data_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ack
grant_o  out  2  one-hot current grant {M1,M0}; 00 when idle

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE, prio pointer=M1 (data wins the first tie), timeout counter=0.
  - All s_* outputs 0, all ack/err outputs 0, grant_o=00.
- A master requests when cyc_i & stb_i.
- States: IDLE, GNT_M0, GNT_M1.
- IDLE:
  - Only one master requesting -> that master's GNT state next cycle.
  - Both requesting -> go to the state named by prio.
  - None requesting -> stay in IDLE.
  - Arbitration latency is 1 cycle: the slave sees the request the cycle after the master asserts it.
- GNT_Mx:
  - s_cyc/stb/we/addr/data_o are combinationally muxed from Mx.
  - s_stb_o = mx_stb_i & mx_cyc_i.
  - mx_ack_o = s_ack_i, same cycle. The other master's ack/err stay 0.
- m0_data_o and m1_data_o are both driven with s_data_i; only the ack qualifies the data.
- s_ack_i in GNT_Mx -> next state IDLE; prio moves to the other master. Each grant covers exactly one transfer.
- Mx drops cyc_i in GNT_Mx without ack (abort):
  - s_cyc_o and s_stb_o fall that same cycle.
  - Next state IDLE; prio is unchanged.
- Timeout counter:
  - Clears on every state entry.
  - Increments each cycle in GNT_Mx without s_ack_i.
  - When it equals TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0): mx_err_o=1 for 1 cycle, s_cyc_o/s_stb_o forced 0 that cycle, next state IDLE, prio moves to the other master.
  - If s_ack_i arrives in the same cycle as the timeout, ack wins and no err is raised.
- s_ack_i while in IDLE is ignored; no ack reaches either master.
- A second transfer needs at least 1 IDLE cycle. Back-to-back requests from both masters therefore alternate M1, M0, M1...
- Reset mid-transfer: everything returns to the reset state on the next edge. A slave ack arriving after reset is ignored.
- grant_o is 01 in GNT_M0, 10 in GNT_M1, 00 in IDLE.

Decomposition:
- Package wb_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT_M0, GNT_M1};
  - localparam encodings GRANT_NONE / GRANT_M0 / GRANT_M1 for grant_o;
  - typedef master_id_t for the prio pointer.
- Sub-module wb_bus_timeout: counter with clear, enable, and an expired output, parameterised by TIMEOUT_CYCLES and TIMEOUT_WIDTH. Instantiated once.

Test Plan:
- Reset, then M0 reads 0x0000_0010 with slave ack 2 cycles later and s_data_i=0xDEAD_BEEF -> grant_o=01 one cycle after request; m0_ack_o=1 with m0_data_o=0xDEAD_BEEF; m1_ack_o stays 0; back to IDLE.
- Both masters request in the same cycle straight after reset -> M1 granted first (grant_o=10), then M0 after 1 IDLE cycle; a repeat of the tie grants M1 again.
- M1 writes 0x1234_5678 to 0x8000_0004 -> s_we_o=1, s_addr_o=0x8000_0004, s_data_o=0x1234_5678 while granted; ack goes to M1 only.
- TIMEOUT_CYCLES=4, slave never acks M0 -> m0_err_o pulses exactly 1 cycle on the 4th grant cycle; s_cyc_o=0; the next M1 request is served normally.
- M0 drops cyc after 1 granted cycle -> s_cyc_o=0 the same cycle; IDLE next cycle; a late s_ack_i produces no ack on either master.
- rst asserted while GNT_M1 is waiting -> all outputs 0 the next cycle; grant_o=00; prio=M1.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types for the two-master Wishbone memory arbiter: FSM states,
// grant encodings and the round-robin priority pointer.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    MID_M0 = 1'b0,
    MID_M1 = 1'b1
  } master_id_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic arb_state_t gnt_state(input master_id_t id);
    return (id == MID_M1) ? GNT_M1 : GNT_M0;
  endfunction

  function automatic master_id_t other_master(input master_id_t id);
    return (id == MID_M1) ? MID_M0 : MID_M1;
  endfunction

endpackage

// File: rtl/wb_bus_timeout.sv
// Grant watchdog: counts unacknowledged grant cycles and flags the cycle
// that completes TIMEOUT_CYCLES of waiting. TIMEOUT_CYCLES of 0 disables it.
module wb_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The counter holds the number of earlier waiting cycles, so the cycle
  // that reaches TIMEOUT_CYCLES sees count == TIMEOUT_CYCLES-1.
  localparam logic [TIMEOUT_WIDTH-1:0] LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wishbone-classic arbiter with round-robin grant,
// one transfer per grant, and an optional bus timeout reported as err.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  // Handshake: a master requests with cyc & stb and holds the request until
  // it sees ack or err; the slave completes a transfer by pulsing s_ack_i
  // while the arbiter presents cyc & stb. Dropping cyc abandons the request.

  arb_state_t state;
  master_id_t prio;

  logic m0_req, m1_req;
  logic in_m0, in_m1;
  logic g_cyc, g_stb;
  logic tmo_en, expired;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;
  assign in_m0  = (state == GNT_M0);
  assign in_m1  = (state == GNT_M1);

  assign g_cyc = (in_m0 & m0_cyc_i) | (in_m1 & m1_cyc_i);
  assign g_stb = (in_m0 & m0_req) | (in_m1 & m1_req);

  // Only a still-active granted cycle that is not being acked counts as waiting.
  assign tmo_en = g_cyc & ~s_ack_i;

  wb_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (tmo_en),
    .expired (expired)
  );

  always_comb begin
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (in_m0) begin
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (in_m1) begin
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign s_cyc_o = g_cyc & ~expired;
  assign s_stb_o = g_stb & ~expired;

  assign m0_ack_o  = in_m0 & s_ack_i;
  assign m1_ack_o  = in_m1 & s_ack_i;
  assign m0_err_o  = in_m0 & expired;
  assign m1_err_o  = in_m1 & expired;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  always_comb begin
    unique case (state)
      GNT_M0:  grant_o = GRANT_M0;
      GNT_M1:  grant_o = GRANT_M1;
      default: grant_o = GRANT_NONE;
    endcase
  end

  // Completion and timeout hand priority to the other master; an abort
  // leaves it alone so the aborting master keeps its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= MID_M1;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_req && m1_req) state <= gnt_state(prio);
          else if (m0_req)      state <= GNT_M0;
          else if (m1_req)      state <= GNT_M1;
        end
        GNT_M0: begin
          if (s_ack_i) begin
            state <= IDLE;
            prio  <= other_master(MID_M0);
          end else if (!m0_cyc_i) begin
            state <= IDLE;
          end else if (expired) begin
            state <= IDLE;
            prio  <= other_master(MID_M0);
          end
        end
        GNT_M1: begin
          if (s_ack_i) begin
            state <= IDLE;
            prio  <= other_master(MID_M1);
          end else if (!m1_cyc_i) begin
            state <= IDLE;
          end else if (expired) begin
            state <= IDLE;
            prio  <= other_master(MID_M1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a directed cycle table for the listed corner
// cases, then random traffic checked against a transfer-level model.
module tb_wb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TB_TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [1:0]    cyc_v = '0, stb_v = '0, we_v = '0;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] wdata_v [2];
  logic [DW-1:0] s_data_i = '0;
  logic          s_ack_i = 1'b0;

  logic [DW-1:0] m0_data_o, m1_data_o, s_data_o;
  logic [AW-1:0] s_addr_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [1:0]    grant_o;

  wb_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TB_TMO), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(cyc_v[0]), .m0_stb_i(stb_v[0]), .m0_we_i(we_v[0]),
    .m0_addr_i(addr_v[0]), .m0_data_i(wdata_v[0]),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc_v[1]), .m1_stb_i(stb_v[1]), .m1_we_i(we_v[1]),
    .m1_addr_i(addr_v[1]), .m1_data_i(wdata_v[1]),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [127:0] act_ctl();
    return 128'({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
  endfunction

  function automatic logic [127:0] act_bus();
    return {s_addr_o, s_data_o, m0_data_o, m1_data_o};
  endfunction

  typedef struct {
    bit         rst;
    bit         chk;
    bit         c0;
    bit         c1;
    bit         ack;
    logic [1:0] grant;
    bit         scyc;
    bit         a0;
    bit         a1;
    bit         e0;
    bit         e1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, chk, c0, c1, ack, input logic [1:0] g,
                     input bit sc, a0, a1, e0, e1);
    vec_t v;
    v.rst = r; v.chk = chk; v.c0 = c0; v.c1 = c1; v.ack = ack;
    v.grant = g; v.scyc = sc; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
    tbl.push_back(v);
  endtask

  // Transfer-level reference: who owns the bus, whose turn a tie is, and how
  // long the owner has waited without an ack.
  int own, prio, waited;
  bit synced;

  initial begin
    logic [127:0] e_ctl, e_bus;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0] e_gr;
    bit e_we, e_sw;

    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;

    // Columns: rst chk c0 c1 ack | grant s_cyc ack0 ack1 err0 err1
    add(1,0,0,0,0, 2'b00,0,0,0,0,0);  // reset
    add(0,1,0,0,0, 2'b00,0,0,0,0,0);  // reset state
    add(0,1,1,0,0, 2'b00,0,0,0,0,0);  // M0 read request
    add(0,1,1,0,0, 2'b01,1,0,0,0,0);
    add(0,1,1,0,1, 2'b01,1,1,0,0,0);  // ack with DEADBEEF
    add(0,1,0,0,0, 2'b00,0,0,0,0,0);
    add(0,1,1,1,0, 2'b00,0,0,0,0,0);  // tie, prio M1
    add(0,1,1,1,1, 2'b10,1,0,1,0,0);  // M1 write
    add(0,1,1,1,0, 2'b00,0,0,0,0,0);
    add(0,1,1,1,1, 2'b01,1,1,0,0,0);
    add(0,1,1,1,0, 2'b00,0,0,0,0,0);
    add(0,1,1,1,1, 2'b10,1,0,1,0,0);  // tie repeats to M1
    add(0,1,0,0,0, 2'b00,0,0,0,0,0);
    add(0,1,1,0,0, 2'b00,0,0,0,0,0);  // M0 never acked
    add(0,1,1,0,0, 2'b01,1,0,0,0,0);
    add(0,1,1,0,0, 2'b01,1,0,0,0,0);
    add(0,1,1,0,0, 2'b01,1,0,0,0,0);
    add(0,1,1,0,0, 2'b01,0,0,0,1,0);  // 4th grant cycle: err
    add(0,1,0,1,0, 2'b00,0,0,0,0,0);
    add(0,1,0,1,1, 2'b10,1,0,1,0,0);  // M1 served normally
    add(0,1,0,0,0, 2'b00,0,0,0,0,0);
    add(0,1,1,0,0, 2'b00,0,0,0,0,0);  // M0 abort
    add(0,1,1,0,0, 2'b01,1,0,0,0,0);
    add(0,1,0,0,0, 2'b01,0,0,0,0,0);
    add(0,1,0,0,1, 2'b00,0,0,0,0,0);  // late ack ignored
    add(0,1,1,1,0, 2'b00,0,0,0,0,0);
    add(0,1,1,1,1, 2'b01,1,1,0,0,0);  // abort kept prio at M0
    add(0,1,0,1,0, 2'b00,0,0,0,0,0);
    add(1,1,0,1,0, 2'b10,1,0,0,0,0);  // rst while M1 waits
    add(0,1,0,0,1, 2'b00,0,0,0,0,0);  // ack after reset ignored
    add(0,1,1,1,0, 2'b00,0,0,0,0,0);
    add(0,1,1,1,1, 2'b10,1,0,1,0,0);  // prio back to M1
    add(0,1,0,0,0, 2'b00,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst;
      cyc_v = {tbl[i].c1, tbl[i].c0};
      stb_v = {tbl[i].c1, tbl[i].c0};
      we_v = 2'b10;
      addr_v[0] = 32'h0000_0010; wdata_v[0] = '0;
      addr_v[1] = 32'h8000_0004; wdata_v[1] = 32'h1234_5678;
      s_data_i = 32'hDEAD_BEEF;
      s_ack_i = tbl[i].ack;
      @(negedge clk);
      if (tbl[i].chk) begin
        e_we = (tbl[i].grant == 2'b10);
        e_ctl = 128'({tbl[i].grant, tbl[i].scyc, tbl[i].scyc, e_we,
                      tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1});
        e_addr = (tbl[i].grant == 2'b01) ? 32'h0000_0010 :
                 (tbl[i].grant == 2'b10) ? 32'h8000_0004 : 32'h0;
        e_wd = (tbl[i].grant == 2'b10) ? 32'h1234_5678 : 32'h0;
        check("tbl_ctl", i, act_ctl(), e_ctl);
        check("tbl_bus", i, act_bus(), {e_addr, e_wd, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
      end
    end

    own = -1; prio = 1; waited = 0; synced = 0;
    for (int n = 0; n < 3000; n++) begin
      int cur;
      bit g_cyc, expire, req0, req1;
      @(posedge clk); #1;
      rst = (n == 0) || ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        if (cyc_v[m]) cyc_v[m] = ($urandom_range(0, 7) != 0);
        else          cyc_v[m] = ($urandom_range(0, 2) == 0);
        stb_v[m] = ($urandom_range(0, 4) != 0);
        we_v[m] = 1'($urandom_range(0, 1));
        addr_v[m] = $urandom;
        wdata_v[m] = $urandom;
      end
      s_data_i = $urandom;
      s_ack_i = ($urandom_range(0, 4) == 0);
      @(negedge clk);

      e_gr = 2'b00; e_sw = 0; e_we = 0; e_addr = '0; e_wd = '0;
      g_cyc = 0; expire = 0;
      e_ctl = '0;
      if (own >= 0) begin
        g_cyc = cyc_v[own];
        expire = (TB_TMO != 0) && g_cyc && !s_ack_i && (waited + 1 == TB_TMO);
        e_gr = (own == 1) ? 2'b10 : 2'b01;
        e_sw = g_cyc && !expire;
        e_we = we_v[own];
        e_addr = addr_v[own];
        e_wd = wdata_v[own];
        e_ctl = 128'({e_gr, e_sw, e_sw && stb_v[own], e_we,
                      (own == 0) && s_ack_i, (own == 1) && s_ack_i,
                      (own == 0) && expire, (own == 1) && expire});
      end
      e_bus = {e_addr, e_wd, s_data_i, s_data_i};
      if (synced) begin
        check("rnd_ctl", n, act_ctl(), e_ctl);
        check("rnd_bus", n, act_bus(), e_bus);
      end

      cur = own;
      if (rst) begin
        own = -1; prio = 1; waited = 0; synced = 1;
      end else if (cur >= 0) begin
        if (s_ack_i || expire) begin
          prio = 1 - cur; own = -1;
        end else if (!g_cyc) begin
          own = -1;
        end else begin
          waited++;
        end
      end else begin
        req0 = cyc_v[0] && stb_v[0];
        req1 = cyc_v[1] && stb_v[1];
        if (req0 && req1) own = prio;
        else if (req0)    own = 0;
        else if (req1)    own = 1;
        waited = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
